mux_scan_n_1: RTL and testbench

Parametrised, registered N:1 channel selector with an auto-scan mode. It selects one WIDTH-bit channel out of N_CH, either on command (manual) or by cycling round-robin through an enable mask (scan), and presents each sample on a valid/ready output. It is the clocked, multi-bit successor to the fixed 16:1 gate-level mux and sits between parallel sources and a single serial consumer.

---
 rtl/mux_scan_n_1_pkg.sv | 22 ++
 rtl/mux_scan_n_1_if.sv | 42 ++++
 rtl/mux_n_1_gate.sv | 25 ++
 rtl/mux_scan_n_1.sv | 130 +++++++++++++
 tb/tb_mux_scan_n_1.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_n_1_pkg.sv
// mux_scan_n_1_pkg
// Shared definitions for the registered N:1 channel selector: FSM state
// encodings, operating-mode constants and parameter-range helpers.
package mux_scan_n_1_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int N_CH_MIN = 2;
    localparam int N_CH_MAX = 256;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/mux_scan_n_1_if.sv
// mux_scan_n_1_if
// Bus between the parallel sources / serial consumer and the selector.
//   inp        N_CH*WIDTH  channel k on bits [k*WIDTH +: WIDTH]
//   mode       1           0 = manual, 1 = scan
//   sel_in     SEL_W       manual channel index
//   sel_load   1           manual request strobe
//   ch_en      N_CH        scan enable mask
//   out_data   WIDTH       captured sample
//   out_sel    SEL_W       channel index of out_data
//   out_valid  1           out_data holds a sample
//   out_ready  1           consumer accepts on out_valid && out_ready
//   scan_wrap  1           one-cycle pulse when the scan pointer wraps
// master: the environment driving sources and consuming samples.
// slave : the selector itself.
interface mux_scan_n_1_if #(
    parameter int N_CH  = 16,
    parameter int WIDTH = 1
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH*WIDTH-1:0] inp;
    logic                  mode;
    logic [SEL_W-1:0]      sel_in;
    logic                  sel_load;
    logic [N_CH-1:0]       ch_en;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_valid;
    logic                  out_ready;
    logic                  scan_wrap;

    modport master (
        output inp, mode, sel_in, sel_load, ch_en, out_ready,
        input  out_data, out_sel, out_valid, scan_wrap
    );

    modport slave (
        input  inp, mode, sel_in, sel_load, ch_en, out_ready,
        output out_data, out_sel, out_valid, scan_wrap
    );

endinterface

// File: rtl/mux_n_1_gate.sv
// mux_n_1_gate
// Purely combinational N:1 data path: data = inp[ptr].
//   inp   N_CH*WIDTH  packed channels, channel k on bits [k*WIDTH +: WIDTH]
//   ptr   SEL_W       channel index
//   data  WIDTH       selected channel
module mux_n_1_gate #(
    parameter  int N_CH  = 16,
    parameter  int WIDTH = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH*WIDTH-1:0] inp,
    input  logic [SEL_W-1:0]      ptr,
    output logic [WIDTH-1:0]      data
);

    logic [WIDTH-1:0] ch [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_split
        assign ch[k] = inp[k*WIDTH +: WIDTH];
    end

    // N_CH is a power of two, so every ptr value addresses a real channel.
    assign data = ch[ptr];

endmodule

// File: rtl/mux_scan_n_1.sv
// mux_scan_n_1
// Registered N:1 channel selector with manual and round-robin scan modes.
// Each selected channel is captured into out_data and offered on a
// valid/ready handshake; in scan mode the next enabled channel is captured
// straight after each transfer (one sample per two cycles at full rate).
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  mux_scan_n_1_if.slave (sources, controls, output handshake)
module mux_scan_n_1 #(
    parameter int N_CH  = 16,
    parameter int WIDTH = 1
) (
    input logic           clk,
    input logic           rst,
    mux_scan_n_1_if.slave bus
);
    import mux_scan_n_1_pkg::*;

    localparam int SEL_W = $clog2(N_CH);

    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX || !is_pow2(N_CH)) begin : g_bad_n_ch
        $error("mux_scan_n_1: N_CH must be a power of two in 2..256");
    end

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] out_sel_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             scan_wrap_q;

    logic [WIDTH-1:0] sel_data;
    logic [SEL_W-1:0] first_incl;   // first enabled channel at or after ptr
    logic [SEL_W-1:0] next_excl;    // first enabled channel after ptr, ptr last
    logic             handshake;

    // Circular search: rotate the mask so 'start' sits at bit 0, take the
    // lowest set bit, then add 'start' back. The SEL_W-bit add wraps modulo
    // N_CH for free. Callers only use the result when mask != 0.
    function automatic logic [SEL_W-1:0] first_enabled(
        input logic [N_CH-1:0]  mask,
        input logic [SEL_W-1:0] start
    );
        logic [2*N_CH-1:0] dbl;
        logic [N_CH-1:0]   rot;
        logic [SEL_W-1:0]  off;
        dbl = {mask, mask} >> start;
        rot = dbl[N_CH-1:0];
        off = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
        return start + off;
    endfunction

    assign first_incl = first_enabled(bus.ch_en, ptr);
    assign next_excl  = first_enabled(bus.ch_en, ptr + SEL_W'(1));
    assign handshake  = out_valid_q && bus.out_ready;

    mux_n_1_gate #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH)
    ) u_gate (
        .inp  (bus.inp),
        .ptr  (ptr),
        .data (sel_data)
    );

    // NOTE: every register here uses non-blocking assignment so all of them
    // update together at the edge, whatever order the statements are in.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous: it is just the highest-priority branch
        // of the clocked logic, so it never acts between edges.
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            scan_wrap_q <= 1'b0;
        end else begin
            scan_wrap_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Manual mode looks only at sel_load/sel_in, scan mode
                    // only at ch_en.
                    if (bus.mode == MODE_MANUAL) begin
                        if (bus.sel_load) begin
                            ptr   <= bus.sel_in;
                            state <= S_CAPTURE;
                        end
                    end else if (|bus.ch_en) begin
                        ptr   <= first_incl;
                        state <= S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    out_data_q  <= sel_data;
                    out_sel_q   <= ptr;
                    out_valid_q <= 1'b1;
                    state       <= S_HOLD;
                end

                S_HOLD: begin
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                        if (bus.mode == MODE_SCAN && |bus.ch_en) begin
                            ptr         <= next_excl;
                            // Not moving forward means we went round the end;
                            // a lone enabled channel wraps on every transfer.
                            scan_wrap_q <= (next_excl <= ptr);
                            state       <= S_CAPTURE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_mux_scan_n_1.sv
// tb_mux_scan_n_1
// Self-checking bench for mux_scan_n_1 (N_CH=16, WIDTH=8). Inputs are driven
// and outputs checked on the falling edge. Expected channels come from a
// plain modulo search over the enable mask; expected data is the channel
// slice of inp as it stood at the capture edge.
module tb_mux_scan_n_1;

    localparam int N = 16;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux_scan_n_1_if #(.N_CH(N), .WIDTH(W)) bus ();

    mux_scan_n_1 #(.N_CH(N), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;   // model of the channel pointer

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic rand_inp();
        bus.inp = {$urandom, $urandom, $urandom, $urandom};
    endtask

    function automatic logic [W-1:0] chan_of(input logic [N*W-1:0] v, input int k);
        return v[k*W +: W];
    endfunction

    // First enabled channel searching circularly from 'from', inclusive.
    function automatic int next_en(input logic [N-1:0] m, input int from);
        for (int k = 0; k < N; k++) begin
            if (m[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic manual_run(input int ch);
        logic [W-1:0] exp_d;
        bus.mode      = 1'b0;
        bus.sel_in    = 4'(ch);
        bus.sel_load  = 1'b1;
        bus.ch_en     = 16'($urandom);
        bus.out_ready = 1'b0;
        cyc();
        bus.sel_load = 1'b0;
        check("man_capture_wait", 32'(bus.out_valid), 0);
        exp_d = chan_of(bus.inp, ch);
        cyc();
        check("man_valid", 32'(bus.out_valid), 1);
        check("man_sel", 32'(bus.out_sel), ch);
        check("man_data", 32'(bus.out_data), 32'(exp_d));
        m_ptr = ch;
        // New data and a fresh request while holding must not disturb output.
        rand_inp();
        bus.sel_in   = 4'(ch + 3);
        bus.sel_load = 1'b1;
        cyc();
        bus.sel_load = 1'b0;
        check("man_hold_data", 32'(bus.out_data), 32'(exp_d));
        check("man_hold_sel", 32'(bus.out_sel), ch);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        check("man_done_valid", 32'(bus.out_valid), 0);
        check("man_done_wrap", 32'(bus.scan_wrap), 0);
        cyc();
        check("man_idle_valid", 32'(bus.out_valid), 0);
    endtask

    task automatic scan_run(input string tag, input logic [N-1:0] mask,
                            input int transfers, input int stall_pct);
        int           cur;
        int           nxt;
        int           stalls;
        bit           last;
        logic [W-1:0] held;
        bus.mode      = 1'b1;
        bus.ch_en     = mask;
        bus.out_ready = 1'b0;
        bus.sel_load  = 1'b0;
        cur = next_en(mask, m_ptr);
        cyc();
        check({tag, "_start_wait"}, 32'(bus.out_valid), 0);
        cyc();
        for (int t = 0; t < transfers; t++) begin
            held = chan_of(bus.inp, cur);
            check({tag, "_valid"}, 32'(bus.out_valid), 1);
            check({tag, "_sel"}, 32'(bus.out_sel), cur);
            check({tag, "_data"}, 32'(bus.out_data), 32'(held));
            check({tag, "_wrap_idle"}, 32'(bus.scan_wrap), 0);
            stalls = 0;
            while (stalls < 5 && $urandom_range(99) < stall_pct) begin
                rand_inp();
                bus.ch_en    = 16'($urandom);
                bus.mode     = 1'($urandom);
                bus.sel_load = 1'($urandom);
                bus.sel_in   = 4'($urandom);
                cyc();
                stalls++;
                check({tag, "_stall_valid"}, 32'(bus.out_valid), 1);
                check({tag, "_stall_sel"}, 32'(bus.out_sel), cur);
                check({tag, "_stall_data"}, 32'(bus.out_data), 32'(held));
            end
            bus.ch_en    = mask;
            bus.mode     = 1'b1;
            bus.sel_load = 1'b0;
            last = (t == transfers - 1);
            if (last) begin
                if ($urandom_range(1) == 1) bus.ch_en = '0;
                else                        bus.mode  = 1'b0;
            end
            bus.out_ready = 1'b1;
            cyc();
            bus.out_ready = 1'b0;
            check({tag, "_hs_valid"}, 32'(bus.out_valid), 0);
            if (last) begin
                check({tag, "_end_wrap"}, 32'(bus.scan_wrap), 0);
                m_ptr = cur;
                cyc();
                check({tag, "_end_idle"}, 32'(bus.out_valid), 0);
            end else begin
                nxt = next_en(mask, (cur + 1) % N);
                check({tag, "_wrap"}, 32'(bus.scan_wrap), 32'(nxt <= cur));
                cur   = nxt;
                m_ptr = cur;
                cyc();
            end
        end
    endtask

    initial begin
        logic [N-1:0] mask;
        rst           = 1'b1;
        bus.inp       = '0;
        bus.mode      = 1'b0;
        bus.sel_in    = '0;
        bus.sel_load  = 1'b0;
        bus.ch_en     = '0;
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_sel", 32'(bus.out_sel), 0);
        check("rst_data", 32'(bus.out_data), 0);
        check("rst_wrap", 32'(bus.scan_wrap), 0);
        rst   = 1'b0;
        m_ptr = 0;

        // Scan order 0, 2, 15, 0 with a wrap only on 15 -> 0.
        rand_inp();
        scan_run("scan_8005", 16'h8005, 4, 0);
        // Mask was cleared at the end; a new single-bit mask restarts at 8.
        scan_run("scan_0100", 16'h0100, 2, 0);

        // Single channel: same channel every transfer, wrap on each.
        bus.inp = '0;
        bus.inp[3*W +: W] = 8'hA5;
        scan_run("single_ch3", 16'h0008, 3, 0);

        // Backpressure: five held cycles per sample with inputs churning.
        rand_inp();
        scan_run("backpressure", 16'h1234, 3, 100);

        // Manual selects.
        bus.inp = '0;
        bus.inp[5*W +: W] = 8'h01;
        manual_run(5);
        manual_run(4);
        for (int i = 0; i < 6; i++) begin
            rand_inp();
            manual_run(int'($urandom_range(N - 1)));
        end

        // Random scan runs from wherever the pointer was left.
        for (int i = 0; i < 10; i++) begin
            mask = 16'($urandom);
            if (mask == '0) mask = 16'h0001;
            rand_inp();
            scan_run("rand_scan", mask, int'($urandom_range(1, 6)), 40);
        end

        // Reset while holding a sample.
        rand_inp();
        bus.mode     = 1'b0;
        bus.sel_in   = 4'd9;
        bus.sel_load = 1'b1;
        cyc();
        bus.sel_load = 1'b0;
        cyc();
        check("hold_before_rst", 32'(bus.out_valid), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("hold_rst_valid", 32'(bus.out_valid), 0);
        check("hold_rst_sel", 32'(bus.out_sel), 0);
        check("hold_rst_data", 32'(bus.out_data), 0);
        check("hold_rst_wrap", 32'(bus.scan_wrap), 0);
        m_ptr = 0;
        // All channels enabled: first capture shows where ptr was left.
        scan_run("post_rst", 16'hFFFF, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
